// File: rtl/scaler_v_pkg.sv
// rtl/scaler_v_pkg.sv - shared FSM states and helpers for the vertical linear scaler
package scaler_v_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        EMIT      = 2'd2
    } state_t;

    // Shift that turns a LINE_STEP-scaled position into an input line index.
    function automatic int log2_line_step(input int line_step);
        return $clog2(line_step);
    endfunction

endpackage

// File: rtl/scaler_v_linebuf.sv
// rtl/scaler_v_linebuf.sv - simple dual-port line buffer RAM, one-cycle read latency
//
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr/rdata read port; rdata is valid the cycle after re
module scaler_v_linebuf #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scaler_v_lin.sv
// rtl/scaler_v_lin.sv - vertical linear-interpolation scaler for single-component video
//
// Build option: define SCALER_V_ROUND_EN to round the blend to nearest; otherwise it truncates.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   line_in_size            input pixels per line minus 1 (static during a frame)
//   scale_step              output line pitch in LINE_STEP units, latched at frame start
//   di_i, de_i, hs_i, vs_i  input pixel, pixel valid, horizontal blank, frame active
//   do_o, de_o, hs_o, vs_o  output pixel, pixel valid, horizontal blank, frame active
module scaler_v_lin
    import scaler_v_pkg::*;
#(
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 128,
    parameter int PIXEL_WIDTH      = 8,
    parameter int SPARSE_OUT       = 0,
    parameter int COE_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            line_in_size,
    input  logic [15:0]            scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int LS_SHIFT = log2_line_step(LINE_STEP);
    localparam int ADDR_W   = $clog2(LINE_IN_SIZE_MAX);
    localparam int GAP_W    = (SPARSE_OUT > 0) ? $clog2(SPARSE_OUT + 1) : 1;
    localparam int PROD_W   = PIXEL_WIDTH + COE_WIDTH;
    localparam int SUM_W    = PROD_W + 1;

`ifdef SCALER_V_ROUND_EN
    localparam logic [SUM_W-1:0] RND = SUM_W'(LINE_STEP / 2);
`else
    localparam logic [SUM_W-1:0] RND = '0;
`endif

    // ---------------------------------------------------------------- input side
    logic        vs_q, hs_q;
    logic        vs_rise, hs_rise;
    logic [15:0] wr_cnt;
    logic [15:0] n_in;
    logic [15:0] step_q;
    logic        wr_en;

    assign vs_rise = vs_i & ~vs_q;
    assign hs_rise = hs_i & ~hs_q;

    // Pixels past line_in_size (or past the buffer) are dropped.
    assign wr_en = de_i & ~hs_i & (wr_cnt <= line_in_size)
                 & (wr_cnt < 16'(LINE_IN_SIZE_MAX));

    // Edge detectors reset to 1 so that leaving reset inside an active frame
    // does not look like a frame or line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b1;
            hs_q   <= 1'b1;
            wr_cnt <= '0;
            n_in   <= '0;
            step_q <= '0;
        end else begin
            vs_q <= vs_i;
            hs_q <= hs_i;
            if (hs_i) begin
                wr_cnt <= '0;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (vs_rise) begin
                n_in   <= '0;
                step_q <= scale_step;
            end else if (hs_rise) begin
                n_in <= n_in + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------- control
    state_t                state, state_nxt;
    logic [31:0]           pos;
    logic [31:0]           l0;
    logic [LS_SHIFT-1:0]   f_cur;
    logic                  ready;
    logic [15:0]           pix_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  emit_lead;
    logic                  issue, last_issue;
    logic                  pipe_idle;
    logic                  frame_done;

    assign l0    = pos >> LS_SHIFT;
    assign f_cur = pos[LS_SHIFT-1:0];

    // An unblended line (f=0) needs only L0; a blended one also needs L1.
    assign ready = (f_cur == '0) ? (l0 < {16'd0, n_in})
                                 : ((l0 + 32'd1) < {16'd0, n_in});

    // The first EMIT cycle is a lead-in so the first pixel leaves with the
    // hs_o fall four cycles after EMIT entry.
    assign issue      = (state == EMIT) && !emit_lead && (gap_cnt == '0);
    assign last_issue = issue && (pix_cnt == line_in_size);

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (ready) begin
                    state_nxt = EMIT;
                end else if (!vs_i && pipe_idle) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            EMIT: begin
                if (last_issue) begin
                    state_nxt = WAIT_LINE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            pix_cnt   <= '0;
            gap_cnt   <= '0;
            emit_lead <= 1'b0;
        end else begin
            state     <= state_nxt;
            emit_lead <= (state != EMIT) && (state_nxt == EMIT);
            if (vs_rise) begin
                pos <= '0;
            end else if (last_issue) begin
                pos <= pos + {16'd0, step_q};
            end
            if (state != EMIT) begin
                pix_cnt <= '0;
                gap_cnt <= '0;
            end else if (issue) begin
                pix_cnt <= pix_cnt + 16'd1;
                gap_cnt <= GAP_W'(SPARSE_OUT);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- line buffers
    // Input line n lives in buffer n mod 2, so L0 and L1 are always in
    // opposite buffers and are read in parallel from the same address.
    logic [PIXEL_WIDTH-1:0] q0, q1;
    logic [ADDR_W-1:0]      rd_addr;

    assign rd_addr = ADDR_W'(pix_cnt);

    scaler_v_linebuf #(
        .DEPTH (LINE_IN_SIZE_MAX),
        .WIDTH (PIXEL_WIDTH),
        .ADDR_W(ADDR_W)
    ) u_buf0 (
        .clk  (clk),
        .we   (wr_en & ~n_in[0]),
        .waddr(ADDR_W'(wr_cnt)),
        .wdata(di_i),
        .re   (issue),
        .raddr(rd_addr),
        .rdata(q0)
    );

    scaler_v_linebuf #(
        .DEPTH (LINE_IN_SIZE_MAX),
        .WIDTH (PIXEL_WIDTH),
        .ADDR_W(ADDR_W)
    ) u_buf1 (
        .clk  (clk),
        .we   (wr_en & n_in[0]),
        .waddr(ADDR_W'(wr_cnt)),
        .wdata(di_i),
        .re   (issue),
        .raddr(rd_addr),
        .rdata(q1)
    );

    // ---------------------------------------------------------------- datapath
    // Stage 1: RAM read. The coefficient and buffer swap are captured with
    // the read because pos advances on the last issue of the line.
    logic                   v1, last1, sel1;
    logic [COE_WIDTH-1:0]   f1;
    logic                   v2, last2;
    logic [PROD_W-1:0]      prod0, prod1;
    logic [PIXEL_WIDTH-1:0] q_l0, q_l1;
    logic [COE_WIDTH-1:0]   w0;
    logic [SUM_W-1:0]       sum;
    logic [PIXEL_WIDTH-1:0] pix_res;
    logic                   last_q;
    logic                   unused_sum_bits;

    assign q_l0 = sel1 ? q1 : q0;
    assign q_l1 = sel1 ? q0 : q1;
    assign w0   = COE_WIDTH'(LINE_STEP) - f1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            sel1  <= 1'b0;
            f1    <= '0;
            v2    <= 1'b0;
            last2 <= 1'b0;
            prod0 <= '0;
            prod1 <= '0;
        end else begin
            v1    <= issue;
            last1 <= last_issue;
            sel1  <= l0[0];
            f1    <= COE_WIDTH'(f_cur);
            // Stage 2: weight both lines.
            v2    <= v1;
            last2 <= last1;
            prod0 <= PROD_W'(q_l0) * PROD_W'(w0);
            prod1 <= PROD_W'(q_l1) * PROD_W'(f1);
        end
    end

    // Stage 3: sum and scale back to pixel range; the weights add to
    // LINE_STEP so the result always fits in PIXEL_WIDTH bits.
    assign sum             = {1'b0, prod0} + {1'b0, prod1} + RND;
    assign pix_res         = sum[LS_SHIFT +: PIXEL_WIDTH];
    assign unused_sum_bits = ^{sum[SUM_W-1:LS_SHIFT+PIXEL_WIDTH], sum[LS_SHIFT-1:0]};

    assign pipe_idle = ~(v1 | v2 | last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_o   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b1;
            vs_o   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (v2) begin
                do_o   <= pix_res;
                de_o   <= 1'b1;
                hs_o   <= 1'b0;
                vs_o   <= 1'b1;
                last_q <= last2;
            end else begin
                de_o <= 1'b0;
                if (last_q) begin
                    hs_o   <= 1'b1;
                    last_q <= 1'b0;
                end
                if (frame_done) begin
                    vs_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_scaler_v_lin.sv
// tb/tb_scaler_v_lin.sv - directed self-checking bench for scaler_v_lin
module tb_scaler_v_lin;

    localparam int W     = 24;
    localparam int H     = 24;
    localparam int LS    = 128;
    localparam int BLANK = 120;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] line_in_size;
    logic [15:0] scale_step;
    logic [7:0]  di_i;
    logic        de_i, hs_i, vs_i;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o;

    int checks = 0;
    int errors = 0;
    int fd0    = 0;

    logic [7:0] pix [64][32];
    logic [7:0] sav [64][32];
    int   cur_line     = -1;
    int   px           = 0;
    int   de_bad       = 0;
    int   vs_align_bad = 0;
    int   len_bad      = 0;
    int   frames_done  = 0;
    logic mon_hs_q = 1'b1;
    logic mon_vs_q = 1'b0;
    logic mon_de_q = 1'b0;

    scaler_v_lin #(
        .LINE_IN_SIZE_MAX(1024),
        .LINE_STEP       (LS),
        .PIXEL_WIDTH     (8),
        .SPARSE_OUT      (1),
        .COE_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_in_size(line_in_size),
        .scale_step  (scale_step),
        .di_i        (di_i),
        .de_i        (de_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .do_o        (do_o),
        .de_o        (de_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o)
    );

    always #5 clk = ~clk;

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (vs_o && !mon_vs_q) begin
            cur_line     = -1;
            de_bad       = 0;
            vs_align_bad = 0;
            len_bad      = 0;
            if (!(!hs_o && mon_hs_q)) vs_align_bad++;
        end
        if (!hs_o && mon_hs_q) begin
            cur_line++;
            px = 0;
        end
        if (!hs_o && (de_o == mon_de_q)) de_bad++;
        if (de_o) begin
            if (cur_line >= 0 && cur_line < 64 && px < 32) pix[cur_line][px] = do_o;
            px++;
        end
        if (hs_o && !mon_hs_q && cur_line >= 0 && px != W) len_bad++;
        if (!vs_o && mon_vs_q) frames_done++;
        mon_hs_q = hs_o;
        mon_vs_q = vs_o;
        mon_de_q = de_o;
    end

    function automatic int in_pix(int pat, int y, int x);
        case (pat)
            0:       return y * 10 + x;
            1:       return (x + y) * 5;
            default: return (y % 2 == 1) ? 100 : 0;
        endcase
    endfunction

    function automatic int exp_pix(int pat, int step, int k, int x);
        int p, i, f, a, b, s;
        p = k * step;
        i = p / LS;
        f = p % LS;
        a = in_pix(pat, i, x);
        b = (f == 0) ? 0 : in_pix(pat, i + 1, x);
        s = a * (LS - f) + b * f;
`ifdef SCALER_V_ROUND_EN
        s = s + LS / 2;
`endif
        return s / LS;
    endfunction

    function automatic int exp_lines(int step);
        return ((H - 1) * LS) / step + 1;
    endfunction

    function automatic int pix_errs(int pat, int step);
        int n;
        n = 0;
        for (int k = 0; k < exp_lines(step); k++)
            for (int x = 0; x < W; x++)
                if (int'(pix[k][x]) != exp_pix(pat, step, k, x)) n++;
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int step);
        scale_step = 16'(step);
        fd0        = frames_done;
        vs_i       = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int pat, input int y, input int blank);
        hs_i = 1'b0;
        @(negedge clk);
        for (int x = 0; x < W; x++) begin
            di_i = 8'(in_pix(pat, y, x));
            de_i = 1'b1;
            @(negedge clk);
            de_i = 1'b0;
            @(negedge clk);
        end
        hs_i = 1'b1;
        @(negedge clk);
        repeat (blank) @(negedge clk);
    endtask

    task automatic end_frame(input string tag);
        vs_i = 1'b0;
        for (int i = 0; i < 4000 && frames_done == fd0; i++) @(negedge clk);
        check({tag, "_done"}, int'(frames_done != fd0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input int pat, input int step, input string tag);
        start_frame(step);
        for (int y = 0; y < H; y++) send_line(pat, y, BLANK);
        end_frame(tag);
        check({tag, "_lines"},  cur_line + 1, exp_lines(step));
        check({tag, "_pix"},    pix_errs(pat, step), 0);
        check({tag, "_len"},    len_bad, 0);
        check({tag, "_de"},     de_bad, 0);
        check({tag, "_vsalign"}, vs_align_bad, 0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        line_in_size = 16'd23;
        scale_step   = 16'd128;
        di_i         = '0;
        de_i         = 1'b0;
        hs_i         = 1'b1;
        vs_i         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_do", int'(do_o), 0);
        check("rst_de", int'(de_o), 0);
        check("rst_hs", int'(hs_o), 1);
        check("rst_vs", int'(vs_o), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Unity: ramp passes through unchanged.
        run_frame(0, 128, "unity");
        check("unity_l5x3", int'(pix[5][3]), 53);
        check("unity_lines_hand", cur_line + 1, 24);

        // Downscale 1.40: line 1 blends input lines 1 and 2 with f=51.
        run_frame(1, 179, "down");
        check("down_lines_hand", cur_line + 1, 17);
`ifdef SCALER_V_ROUND_EN
        check("down_l1x0",  int'(pix[1][0]), 7);
        check("down_l1x23", int'(pix[1][23]), 122);
`else
        check("down_l1x0",  int'(pix[1][0]), 6);
        check("down_l1x23", int'(pix[1][23]), 121);
`endif

        // Upscale 2x over alternating 0/100 lines.
        run_frame(2, 64, "up");
        check("up_lines_hand", cur_line + 1, 47);
        check("up_mid", int'(pix[1][5]), 50);
        check("up_l2", int'(pix[2][0]), 100);

        // Decimate by 2: even input lines.
        run_frame(1, 256, "dec");
        check("dec_lines_hand", cur_line + 1, 12);
        check("dec_l3x7", int'(pix[3][7]), 65);
        for (int k = 0; k < 12; k++)
            for (int x = 0; x < W; x++) sav[k][x] = pix[k][x];

        // Second identical frame must reproduce the first.
        run_frame(1, 256, "dec2");
        n = 0;
        for (int k = 0; k < 12; k++)
            for (int x = 0; x < W; x++)
                if (pix[k][x] !== sav[k][x]) n++;
        check("repeat_frame_diff", n, 0);

        // Reset in the middle of an output line.
        start_frame(128);
        for (int y = 0; y < 4; y++) send_line(0, y, BLANK);
        send_line(0, 4, 0);
        n = 0;
        while (hs_o !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_line_active", int'(hs_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_do", int'(do_o), 0);
        check("midrst_de", int'(de_o), 0);
        check("midrst_hs", int'(hs_o), 1);
        check("midrst_vs", int'(vs_o), 0);
        vs_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(1, 179, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
